// File: rtl/uart_msg_framer_if.sv
// uart_msg_framer_if
// Bundles the framer's upstream handshake (message flag, start pulse,
// FIFO read strobe/data) and its downstream valid/ready word stream.
//   master : the framer (drives MSG_START, RD_REQ, TX_*, BUSY)
//   slave  : the surrounding logic (drives GOT_FULL_MESSAGE, MSG_LEN,
//            PARITY_IN, FIFO_Q, TX_READY)
interface uart_msg_framer_if;
    logic        GOT_FULL_MESSAGE;
    logic [7:0]  MSG_LEN;
    logic        PARITY_IN;
    logic [15:0] FIFO_Q;
    logic        MSG_START;
    logic        RD_REQ;
    logic [15:0] TX_DATA;
    logic        TX_VALID;
    logic        TX_READY;
    logic        TX_LAST;
    logic        BUSY;

    modport master (
        input  GOT_FULL_MESSAGE, MSG_LEN, PARITY_IN, FIFO_Q, TX_READY,
        output MSG_START, RD_REQ, TX_DATA, TX_VALID, TX_LAST, BUSY
    );

    modport slave (
        output GOT_FULL_MESSAGE, MSG_LEN, PARITY_IN, FIFO_Q, TX_READY,
        input  MSG_START, RD_REQ, TX_DATA, TX_VALID, TX_LAST, BUSY
    );
endinterface

// File: rtl/uart_msg_framer.sv
// uart_msg_framer
// Pulls one complete message out of the UART input-buffering stage and
// emits it as a framed packet: HEADER, {SRC_ID,len}, {seq,7'b0,parity},
// payload words, checksum (TX_LAST). The checksum is the 16-bit wrapping
// sum of every accepted word except the header and the checksum itself.
// Ports:
//   CLK, RST : system clock, asynchronous active-high reset
//   bus      : uart_msg_framer_if.master (upstream handshake + TX stream)
// All outputs are registered.
module uart_msg_framer #(
    parameter logic [15:0] HEADER        = 16'hA55A,
    parameter logic [7:0]  SRC_ID        = 8'h01,
    parameter int          SETTLE_CYCLES = 4
) (
    input  logic               CLK,
    input  logic               RST,
    uart_msg_framer_if.master  bus
);

    typedef enum logic [3:0] {
        ST_IDLE    = 4'd0,
        ST_START   = 4'd1,
        ST_SETTLE  = 4'd2,
        ST_HDR     = 4'd3,
        ST_LEN     = 4'd4,
        ST_INFO    = 4'd5,
        ST_RDREQ   = 4'd6,
        ST_RDWAIT  = 4'd7,
        ST_PAYLOAD = 4'd8,
        ST_CSUM    = 4'd9
    } state_t;

    localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);

    state_t      state_r;
    logic [7:0]  settle_cnt_r;
    logic [7:0]  len_r;
    logic        par_r;
    logic [7:0]  remaining_r;
    logic [7:0]  seq_r;
    logic [15:0] csum_r;
    logic [15:0] tx_data_r;
    logic        tx_valid_r;
    logic        tx_last_r;
    logic        msg_start_r;
    logic        rd_req_r;
    logic        busy_r;

    logic        accept_s;
    logic [15:0] csum_next_s;

    // Running checksum: plain 16-bit sum, carries out of bit 15 are dropped.
    function automatic logic [15:0] csum_add(input logic [15:0] acc,
                                             input logic [15:0] word);
        return acc + word;
    endfunction

    assign accept_s    = tx_valid_r && bus.TX_READY;
    // Checksum including the word currently on the bus (used on its acceptance).
    assign csum_next_s = csum_add(csum_r, tx_data_r);

    // Packet sequencer: state, counters and every registered output.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_r      <= ST_IDLE;
            settle_cnt_r <= 8'd0;
            len_r        <= 8'd0;
            par_r        <= 1'b0;
            remaining_r  <= 8'd0;
            seq_r        <= 8'd0;
            csum_r       <= 16'd0;
            tx_data_r    <= 16'd0;
            tx_valid_r   <= 1'b0;
            tx_last_r    <= 1'b0;
            msg_start_r  <= 1'b0;
            rd_req_r     <= 1'b0;
            busy_r       <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (bus.GOT_FULL_MESSAGE) begin
                        state_r     <= ST_START;
                        msg_start_r <= 1'b1;
                        busy_r      <= 1'b1;
                    end
                end
                ST_START: begin
                    msg_start_r  <= 1'b0;
                    settle_cnt_r <= 8'd0;
                    state_r      <= ST_SETTLE;
                end
                ST_SETTLE: begin
                    // MSG_LEN/PARITY_IN become valid exactly in the first settle cycle.
                    if (settle_cnt_r == 8'd0) begin
                        len_r       <= bus.MSG_LEN;
                        par_r       <= bus.PARITY_IN;
                        remaining_r <= bus.MSG_LEN;
                        csum_r      <= 16'd0;
                    end
                    settle_cnt_r <= settle_cnt_r + 8'd1;
                    if (settle_cnt_r == SETTLE_LAST) begin
                        state_r    <= ST_HDR;
                        tx_data_r  <= HEADER;
                        tx_valid_r <= 1'b1;
                    end
                end
                ST_HDR: begin
                    // Header is deliberately left out of the checksum.
                    if (accept_s) begin
                        tx_data_r <= {SRC_ID, len_r};
                        state_r   <= ST_LEN;
                    end
                end
                ST_LEN: begin
                    if (accept_s) begin
                        csum_r    <= csum_next_s;
                        tx_data_r <= {seq_r, 7'b0, par_r};
                        state_r   <= ST_INFO;
                    end
                end
                ST_INFO, ST_PAYLOAD: begin
                    // remaining_r was already decremented when this payload word was captured.
                    if (accept_s) begin
                        csum_r <= csum_next_s;
                        if (remaining_r == 8'd0) begin
                            tx_data_r <= csum_next_s;
                            tx_last_r <= 1'b1;
                            state_r   <= ST_CSUM;
                        end else begin
                            tx_valid_r <= 1'b0;
                            rd_req_r   <= 1'b1;
                            state_r    <= ST_RDREQ;
                        end
                    end
                end
                ST_RDREQ: begin
                    rd_req_r <= 1'b0;
                    state_r  <= ST_RDWAIT;
                end
                ST_RDWAIT: begin
                    // FIFO_Q is valid the cycle after the read strobe.
                    tx_data_r   <= bus.FIFO_Q;
                    tx_valid_r  <= 1'b1;
                    remaining_r <= remaining_r - 8'd1;
                    state_r     <= ST_PAYLOAD;
                end
                ST_CSUM: begin
                    if (accept_s) begin
                        tx_data_r  <= 16'd0;
                        tx_valid_r <= 1'b0;
                        tx_last_r  <= 1'b0;
                        seq_r      <= seq_r + 8'd1;
                        busy_r     <= 1'b0;
                        state_r    <= ST_IDLE;
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    tx_valid_r  <= 1'b0;
                    tx_last_r   <= 1'b0;
                    msg_start_r <= 1'b0;
                    rd_req_r    <= 1'b0;
                    busy_r      <= 1'b0;
                end
            endcase
        end
    end

    assign bus.MSG_START = msg_start_r;
    assign bus.RD_REQ    = rd_req_r;
    assign bus.TX_DATA   = tx_data_r;
    assign bus.TX_VALID  = tx_valid_r;
    assign bus.TX_LAST   = tx_last_r;
    assign bus.BUSY      = busy_r;

endmodule

// File: tb/tb_uart_msg_framer.sv
// tb_uart_msg_framer
// Randomized bench for uart_msg_framer. For each packet the bench builds the
// expected word list (header, length, info, payload, checksum) with plain
// arithmetic, plays the upstream FIFO, and compares every presented word.
module tb_uart_msg_framer;

    localparam int SETTLE = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;

    uart_msg_framer_if ifc();

    uart_msg_framer #(
        .HEADER        (16'hA55A),
        .SRC_ID        (8'h01),
        .SETTLE_CYCLES (SETTLE)
    ) dut (
        .CLK (clk),
        .RST (rst),
        .bus (ifc.master)
    );

    always #5 clk = ~clk;

    int          n_vec = 0;
    int          n_err = 0;
    logic [7:0]  seq_m;
    logic [15:0] pl_words [0:255];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_quiet(input string tag);
        chk({tag, "_valid"}, 32'(ifc.TX_VALID), 32'd0);
        chk({tag, "_busy"},  32'(ifc.BUSY),     32'd0);
        chk({tag, "_last"},  32'(ifc.TX_LAST),  32'd0);
        chk({tag, "_data"},  32'(ifc.TX_DATA),  32'd0);
        chk({tag, "_start"}, 32'(ifc.MSG_START), 32'd0);
        chk({tag, "_rdreq"}, 32'(ifc.RD_REQ),   32'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        check_quiet("reset");
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        ifc.GOT_FULL_MESSAGE = 1'b0;
        seq_m = 8'd0;
    endtask

    // One packet: len payload words taken from pl_words. bp randomizes TX_READY.
    // abort_at >= 0 asserts reset when word index abort_at is first presented.
    task automatic run_packet(input int len, input bit par, input bit bp,
                              input int abort_at, input bit chk_lat);
        logic [15:0] exp_q[$];
        logic [15:0] w;
        int sum, idx, rd_cnt, ms_cnt, cyc, ms_cyc, v_cyc;
        bit stall, aborted;
        exp_q.delete();
        sum = 0;
        exp_q.push_back(16'hA55A);
        w = {8'h01, 8'(len)};
        exp_q.push_back(w);
        sum += int'(w);
        w = {seq_m, 7'b0, par};
        exp_q.push_back(w);
        sum += int'(w);
        for (int i = 0; i < len; i++) begin
            exp_q.push_back(pl_words[i]);
            sum += int'(pl_words[i]);
        end
        exp_q.push_back(16'(sum));

        ifc.MSG_LEN = 8'(len);
        ifc.PARITY_IN = par;
        ifc.GOT_FULL_MESSAGE = 1'b1;
        ifc.TX_READY = 1'b1;
        idx = 0; rd_cnt = 0; ms_cnt = 0; cyc = 0;
        ms_cyc = -1; v_cyc = -1; stall = 1'b0; aborted = 1'b0;

        while (idx < exp_q.size() && cyc < 4000) begin
            @(posedge clk);
            #1;
            cyc++;
            if (ifc.MSG_START) begin
                ms_cnt++;
                if (ms_cyc < 0) ms_cyc = cyc;
                ifc.GOT_FULL_MESSAGE = 1'b0;
            end
            if (ifc.RD_REQ) begin
                ifc.FIFO_Q = (rd_cnt < len) ? pl_words[rd_cnt] : 16'hDEAD;
                rd_cnt++;
            end
            if (stall) chk("hold_valid", 32'(ifc.TX_VALID), 32'd1);
            stall = 1'b0;
            if (ifc.TX_VALID) begin
                if (v_cyc < 0) v_cyc = cyc;
                if (abort_at >= 0 && idx == abort_at) begin
                    aborted = 1'b1;
                    break;
                end
                ifc.TX_READY = bp ? 1'($urandom_range(0, 1)) : 1'b1;
                chk("tx_word", {15'b0, ifc.TX_LAST, ifc.TX_DATA},
                    {15'b0, (idx == exp_q.size() - 1), exp_q[idx]});
                if (ifc.TX_READY) idx++;
                else stall = 1'b1;
            end else begin
                ifc.TX_READY = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            end
        end

        if (aborted) begin
            do_reset();
        end else begin
            chk("words_done", 32'(idx), 32'(exp_q.size()));
            chk("rd_req_count", 32'(rd_cnt), 32'(len));
            chk("msg_start_count", 32'(ms_cnt), 32'd1);
            if (chk_lat) chk("start_latency", 32'(v_cyc - ms_cyc), 32'(SETTLE + 1));
            ifc.TX_READY = 1'b1;
            @(posedge clk);
            #1;
            chk("idle_busy", 32'(ifc.BUSY), 32'd0);
            chk("idle_valid", 32'(ifc.TX_VALID), 32'd0);
            seq_m = seq_m + 8'd1;
        end
    endtask

    initial begin
        ifc.GOT_FULL_MESSAGE = 1'b0;
        ifc.MSG_LEN = 8'd0;
        ifc.PARITY_IN = 1'b0;
        ifc.FIFO_Q = 16'd0;
        ifc.TX_READY = 1'b1;
        seq_m = 8'd0;
        #2;
        do_reset();

        // Basic packet, seq 0
        pl_words[0] = 16'h1234;
        pl_words[1] = 16'h5678;
        run_packet(2, 1'b1, 1'b0, -1, 1'b1);
        // Empty message, seq 1
        run_packet(0, 1'b0, 1'b0, -1, 1'b0);

        // Checksum wrap at seq 0
        do_reset();
        pl_words[0] = 16'hFFFF;
        pl_words[1] = 16'hFFFF;
        run_packet(2, 1'b0, 1'b0, -1, 1'b0);

        // Basic words under random backpressure
        pl_words[0] = 16'h1234;
        pl_words[1] = 16'h5678;
        run_packet(2, 1'b1, 1'b1, -1, 1'b0);

        // Random packets
        for (int p = 0; p < 20; p++) begin
            int l;
            l = int'($urandom_range(0, 8));
            for (int i = 0; i < l; i++) pl_words[i] = 16'($urandom);
            run_packet(l, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), -1, 1'b0);
        end

        // Reset while the first payload word is presented, then restart
        for (int i = 0; i < 4; i++) pl_words[i] = 16'($urandom);
        run_packet(4, 1'b1, 1'b0, 3, 1'b0);
        pl_words[0] = 16'hBEEF;
        pl_words[1] = 16'h0F0F;
        run_packet(2, 1'b0, 1'b0, -1, 1'b0);

        // Sequence wrap: packet 256 carries seq FF, packet 257 seq 00
        do_reset();
        for (int p = 0; p < 257; p++) begin
            int l;
            l = int'($urandom_range(0, 2));
            for (int i = 0; i < l; i++) pl_words[i] = 16'($urandom);
            run_packet(l, 1'($urandom_range(0, 1)), (p % 8 == 0), -1, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/uart_msg_framer.md
# uart_msg_framer

Downstream consumer of the UART input-buffering stage. Waits for that stage's full-message flag, starts a message (MSG_START), reads the announced number of 16-bit words through RD_REQ, and emits a framed packet on a 16-bit valid/ready stream toward the transmit path. Each packet has this layout:

- header
- length word
- info (sequence/parity) word
- payload words
- 16-bit checksum word, flagged as the last word

## Interface

Parameters:
- HEADER, 16'hA55A, first word of every packet
- SRC_ID, 8'h01, source identifier placed in the length word
- SETTLE_CYCLES, 4, wait after MSG_START before the first FIFO read (minimum 2)

Ports:
- CLK  in  1  single system clock
- RST  in  1  asynchronous, active-high reset
- GOT_FULL_MESSAGE  in  1  upstream message-ready flag; the upstream stage clears it on RD_REQ
- MSG_LEN  in  8  payload word count; valid from the cycle after MSG_START
- PARITY_IN  in  1  upstream stuffing indicator (odd byte count); valid with MSG_LEN
- FIFO_Q  in  16  upstream FIFO data; normal mode, valid the cycle after RD_REQ
- MSG_START  out  1  one-cycle pulse that starts a message upstream
- RD_REQ  out  1  one-cycle read strobe to the upstream FIFO
- TX_DATA  out  16  packet word
- TX_VALID  out  1  TX_DATA is valid
- TX_READY  in  1  downstream accepts the word when TX_VALID && TX_READY
- TX_LAST  out  1  high with the checksum word only
- BUSY  out  1  high in every state except IDLE

## Operation

States: IDLE, START, SETTLE, HDR, LEN, INFO, RDREQ, RDWAIT, PAYLOAD, CSUM.

- **IDLE:** When GOT_FULL_MESSAGE=1, go to START.
- **START:** MSG_START=1 for exactly this one cycle. Go to SETTLE.
- **SETTLE:** Lasts SETTLE_CYCLES cycles.
  - In the first SETTLE cycle, latch len_r=MSG_LEN and par_r=PARITY_IN.
  - Clear the running checksum and set remaining=len_r.
  - After the last SETTLE cycle, go to HDR.
- **HDR:** TX_DATA=HEADER.
- **LEN:** TX_DATA={SRC_ID, len_r}.
- **INFO:** TX_DATA={seq[7:0], 7'b0, par_r}.
  - After acceptance: if remaining=0 go to CSUM, else go to RDREQ.
- **RDREQ:** RD_REQ=1 for one cycle, then go to RDWAIT.
- **RDWAIT:** Capture FIFO_Q into TX_DATA and decrement remaining. Go to PAYLOAD.
- **PAYLOAD:** Present the captured word.
  - After acceptance: if remaining=0 go to CSUM, else go to RDREQ.
- **CSUM:** TX_DATA=checksum, TX_LAST=1.
  - After acceptance: seq increments (8-bit, 255 wraps to 0) and the block returns to IDLE.

Rules applying across states:
- A state that presents a word (HDR, LEN, INFO, PAYLOAD, CSUM) advances only on acceptance (TX_VALID && TX_READY).
- The checksum is the 16-bit sum, modulo 2^16, of every accepted word except HEADER and the checksum itself.
- Payload words pass through unmodified. The upstream stage has already byte-swapped and stuffed them.
- len_r=0 is legal: the packet is HDR, LEN, INFO, CSUM, and no RD_REQ is issued.
- Exactly len_r RD_REQ pulses are issued per packet. RD_REQ is never issued outside RDREQ.
- GOT_FULL_MESSAGE is ignored everywhere except IDLE.

## Timing

- **Reset values:** MSG_START=0, RD_REQ=0, TX_DATA=0, TX_VALID=0, TX_LAST=0, BUSY=0, seq=0, checksum=0, state=IDLE.
- **Reset mid-packet:** all outputs drop within the reset assertion. After release, the block restarts at IDLE with seq=0. No partial packet resumes.
- **Start latency:** GOT_FULL_MESSAGE sampled at cycle 0 gives MSG_START at cycle 1. Cycles 2..1+SETTLE_CYCLES are SETTLE. TX_VALID rises at cycle 2+SETTLE_CYCLES with HEADER.
- **Backpressure:**
  - TX_VALID is registered and never drops while TX_READY=0.
  - TX_DATA and TX_LAST stay stable while TX_VALID && !TX_READY.
- **Payload throughput:** each payload word costs RDREQ + RDWAIT + at least one PAYLOAD cycle. Rate is one word per 3 cycles with TX_READY held at 1.
- **Back-to-back packets:** a new packet starts at the earliest one cycle after the CSUM acceptance (through IDLE).

## Test plan

- **Basic packet:** len=2, PARITY_IN=1, FIFO words 0x1234, 0x5678, seq=0, TX_READY=1.
  - Stream: A55A, 0102, 0001, 1234, 5678, 69AF. TX_LAST is high on 69AF only.
  - Exactly 2 RD_REQ pulses and 1 MSG_START pulse.
- **Empty message:** len=0, second packet (seq=1), PARITY_IN=0.
  - Stream: A55A, 0100, 0100, 0200.
  - No RD_REQ.
- **Checksum wrap:** len=2, words FFFF, FFFF, parity 0, seq=0.
  - Checksum = (0102+0000+FFFF+FFFF) mod 2^16 = 0x0100.
- **Backpressure:** toggle TX_READY pseudo-randomly during the basic-packet scenario.
  - Same six words in order.
  - TX_DATA is stable while stalled.
  - No extra RD_REQ is issued.
- **Sequence wrap:** send 257 packets.
  - Packet 256 carries seq=0xFF in the INFO word.
  - Packet 257 carries seq=0x00.
- **Reset mid-payload:** assert RST while in PAYLOAD.
  - TX_VALID=0 and BUSY=0 immediately.
  - The next packet starts with HEADER and seq=0.
